slot_sensor_filter: RTL and testbench

upstream conditioning stage. Takes the six raw parking-slot sensors, debounces them, and drives the clean `pos[5:0]` bus consumed by the LCD, LED and gate blocks. Also provides a free-slot count, a lot-full flag and a change strobe.

Interface
- REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive stable cycles required to accept a sensor change (10 ms at 50 MHz); legal values are 2 or more.
- REQ-002 The block SHALL have parameter CNT_W, default 19, the per-channel counter width; it SHALL satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- REQ-003 The block SHALL have port clock_50MHz, input, 1 bit: the single system clock; all logic is on its rising edge.
- REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-005 The block SHALL have port sensor_raw, input, 6 bits: asynchronous raw slot sensors; 1 means occupied.
- REQ-006 The block SHALL have port pos, output, 6 bits, registered: debounced occupancy; bit i means slot i is occupied.
- REQ-007 The block SHALL have port free_count, output, 3 bits, registered: number of zero bits in pos (range 0..6).
- REQ-008 The block SHALL have port full, output, 1 bit, registered: 1 exactly when free_count == 0.
- REQ-009 The block SHALL have port change_strobe, output, 1 bit, registered: one-cycle pulse when any pos bit changes.

Function
- REQ-010 Each sensor_raw bit SHALL pass through its own two-flop synchronizer; the second-stage output is sync[i].
- REQ-011 Each channel SHALL have an independent CNT_W-bit counter cnt[i].
- REQ-012 In any cycle where sync[i] == pos[i], cnt[i] SHALL clear to 0.
- REQ-013 In any cycle where sync[i] != pos[i] and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] SHALL increment by 1.
- REQ-014 In any cycle where sync[i] != pos[i] and cnt[i] == DEBOUNCE_CYCLES-1, pos[i] SHALL take the value of sync[i] and cnt[i] SHALL clear to 0.
- REQ-015 Latency: a raw edge held stable SHALL appear on pos exactly 2 + DEBOUNCE_CYCLES clock edges after the first clock edge that samples the new raw level.
- REQ-016 A raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change pos, free_count, full or change_strobe.
- REQ-017 A bouncing input SHALL restart its channel's count at every return to the pos value; no partial credit is kept.
- REQ-018 free_count and full SHALL be computed from the next-state value of pos and registered on the same edge that updates pos, so they never lag pos.
- REQ-019 change_strobe SHALL be 1 for exactly one cycle, on the same edge that pos changes, whenever the next pos differs from the current pos; otherwise it SHALL be 0.
- REQ-020 When several channels update on the same edge, pos SHALL update all of them together, free_count SHALL reflect all of them, and change_strobe SHALL pulse only once.
- REQ-021 Channels SHALL be fully independent; activity on one channel SHALL NOT affect another channel's counter.
- REQ-022 cnt[i] SHALL never exceed DEBOUNCE_CYCLES-1; there is no wrap-around.
- REQ-023 Arithmetic: free_count SHALL equal 6 minus popcount(pos) in 3-bit unsigned arithmetic.

Reset
- REQ-024 While reset is 1 at a clock edge, the following SHALL all take these values on that edge:
  - synchronizer flops = 0
  - cnt[] = 0
  - pos = 6'b000000
  - free_count = 3'd6
  - full = 0
  - change_strobe = 0
- REQ-025 Reset SHALL take priority over every other update, including an update of pos due on the same edge.
- REQ-026 After reset is released, debounce counting SHALL start from 0; counts in progress before reset are discarded.

Verification (run with DEBOUNCE_CYCLES=4)
- REQ-027 Reset scenario: assert reset for 2 cycles with sensor_raw=6'h3F -> expect pos=0, free_count=6, full=0, change_strobe=0 during reset.
- REQ-028 Single-slot scenario: sensor_raw[0] goes 0->1 and is held -> expect pos=6'h01 exactly 6 edges after the first sampling edge, free_count=5, and a single one-cycle change_strobe.

---
 rtl/slot_sensor_filter.sv | 115 +++++++++++
 tb/tb_slot_sensor_filter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/slot_sensor_filter.sv
// slot_sensor_filter
//   Conditions the six raw parking-slot sensors into a clean occupancy bus.
//   Each channel runs through a two-flop synchronizer and a debounce counter.
//   A new level is accepted only after DEBOUNCE_CYCLES consecutive
//   synchronized cycles that disagree with the current pos value.
//
// Ports
//   clock_50MHz   in   system clock; all logic runs on the rising edge
//   reset         in   synchronous, active-high reset
//   sensor_raw    in   [5:0] asynchronous raw sensors, 1 = occupied
//   pos           out  [5:0] debounced occupancy (registered)
//   free_count    out  [2:0] number of free slots, 6 - popcount(pos) (registered)
//   full          out  1 when free_count == 0 (registered)
//   change_strobe out  one-cycle pulse on the edge where pos changes (registered)

// One debounce channel: synchronizer, counter and the registered pos bit.
// pos_nxt is exposed so the top can derive its summary outputs from the
// value pos is about to take, which keeps them aligned with pos.
module slot_sensor_chan #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pos_q,
    output logic pos_nxt
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    // Any cycle that agrees with pos discards accumulated count, so a
    // bouncing input restarts from zero every time it returns.
    always_comb begin
        pos_nxt = pos_q;
        cnt_nxt = '0;
        if (sync2 != pos_q) begin
            if (cnt == CNT_LAST) begin
                pos_nxt = sync2;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            pos_q <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            cnt   <= cnt_nxt;
            pos_q <= pos_nxt;
        end
    end
endmodule

module slot_sensor_filter #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic       clock_50MHz,
    input  logic       reset,
    input  logic [5:0] sensor_raw,
    output logic [5:0] pos,
    output logic [2:0] free_count,
    output logic       full,
    output logic       change_strobe
);
    localparam int NUM_SLOTS = 6;

    logic [NUM_SLOTS-1:0] pos_nxt;
    logic [2:0]           occupied;
    logic [2:0]           free_nxt;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_chan
        slot_sensor_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_chan (
            .clk    (clock_50MHz),
            .reset  (reset),
            .raw    (sensor_raw[g]),
            .pos_q  (pos[g]),
            .pos_nxt(pos_nxt[g])
        );
    end

    always_comb begin
        occupied = 3'd0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            occupied = occupied + 3'(pos_nxt[i]);
        end
        free_nxt = 3'd6 - occupied;
    end

    // Summary outputs are registered from pos_nxt on the same edge as pos,
    // so simultaneous channel updates yield one strobe and one count step.
    always_ff @(posedge clock_50MHz) begin
        if (reset) begin
            free_count    <= 3'd6;
            full          <= 1'b0;
            change_strobe <= 1'b0;
        end else begin
            free_count    <= free_nxt;
            full          <= (free_nxt == 3'd0);
            change_strobe <= (pos_nxt != pos);
        end
    end
endmodule

// File: tb/tb_slot_sensor_filter.sv
module tb_slot_sensor_filter;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] sensor_raw;
    logic [5:0] pos;
    logic [2:0] free_count;
    logic       full;
    logic       change_strobe;

    int checks   = 0;
    int failures = 0;

    slot_sensor_filter #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clock_50MHz  (clk),
        .reset        (reset),
        .sensor_raw   (sensor_raw),
        .pos          (pos),
        .free_count   (free_count),
        .full         (full),
        .change_strobe(change_strobe)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [5:0] raw;
        logic [5:0] e_pos;
        logic [2:0] e_free;
        logic       e_full;
        logic       e_stb;
    } vec_t;

    vec_t vecs[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [5:0] e_pos,
                              input logic [2:0] e_free, input logic e_full,
                              input logic e_stb);
        check({name, ".pos"},    int'(pos),           int'(e_pos));
        check({name, ".free"},   int'(free_count),    int'(e_free));
        check({name, ".full"},   int'(full),          int'(e_full));
        check({name, ".strobe"}, int'(change_strobe), int'(e_stb));
    endtask

    // Runs max_edges edges with inputs held; reports the 1-based edge on which
    // pos first equals exp (0 if never) and how many strobes were seen.
    task automatic run_until(input logic [5:0] exp, input int max_edges,
                             output int edge_n, output int strobes);
        edge_n  = 0;
        strobes = 0;
        for (int k = 1; k <= max_edges; k++) begin
            tick();
            strobes += int'(change_strobe);
            if (edge_n == 0 && pos === exp) edge_n = k;
        end
    endtask

    int e_n, s_n;

    initial begin
        reset      = 1'b1;
        sensor_raw = 6'h00;

        // Reset with all sensors active, then sensor 0 rises and is held.
        // Edge 1 of the held level is the sampling edge; pos moves on edge 6.
        vecs[0]  = '{"rst0",  1'b1, 6'h3F, 6'h00, 3'd6, 1'b0, 1'b0};
        vecs[1]  = '{"rst1",  1'b1, 6'h3F, 6'h00, 3'd6, 1'b0, 1'b0};
        vecs[2]  = '{"idle",  1'b0, 6'h00, 6'h00, 3'd6, 1'b0, 1'b0};
        vecs[3]  = '{"s0_e1", 1'b0, 6'h01, 6'h00, 3'd6, 1'b0, 1'b0};
        vecs[4]  = '{"s0_e2", 1'b0, 6'h01, 6'h00, 3'd6, 1'b0, 1'b0};
        vecs[5]  = '{"s0_e3", 1'b0, 6'h01, 6'h00, 3'd6, 1'b0, 1'b0};
        vecs[6]  = '{"s0_e4", 1'b0, 6'h01, 6'h00, 3'd6, 1'b0, 1'b0};
        vecs[7]  = '{"s0_e5", 1'b0, 6'h01, 6'h00, 3'd6, 1'b0, 1'b0};
        vecs[8]  = '{"s0_e6", 1'b0, 6'h01, 6'h01, 3'd5, 1'b0, 1'b1};
        vecs[9]  = '{"s0_e7", 1'b0, 6'h01, 6'h01, 3'd5, 1'b0, 1'b0};
        vecs[10] = '{"s0_e8", 1'b0, 6'h01, 6'h01, 3'd5, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            reset      = vecs[i].rst;
            sensor_raw = vecs[i].raw;
            tick();
            check_outs(vecs[i].name, vecs[i].e_pos, vecs[i].e_free,
                       vecs[i].e_full, vecs[i].e_stb);
        end

        // Glitch: sensor 2 high for 3 sampled cycles only.
        sensor_raw = 6'h05;
        for (int i = 0; i < 3; i++) tick();
        sensor_raw = 6'h01;
        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (pos !== 6'h01 || free_count !== 3'd5 || change_strobe !== 1'b0) bad++;
            end
            check("glitch.disturbed_cycles", bad, 0);
        end

        // All sensors at once: one edge, one strobe.
        sensor_raw = 6'h3F;
        run_until(6'h3F, 10, e_n, s_n);
        check("simul.edge", e_n, 6);
        check("simul.strobes", s_n, 1);
        check_outs("simul.final", 6'h3F, 3'd0, 1'b1, 1'b0);

        sensor_raw = 6'h1F;
        run_until(6'h1F, 10, e_n, s_n);
        check("rel5.edge", e_n, 6);
        check("rel5.strobes", s_n, 1);
        check_outs("rel5.final", 6'h1F, 3'd1, 1'b0, 1'b0);

        // Reset mid-count; pos[1] would have risen on the reset edge.
        reset = 1'b1; sensor_raw = 6'h00; tick();
        reset = 1'b0; tick();
        check_outs("mid.clean", 6'h00, 3'd6, 1'b0, 1'b0);
        sensor_raw = 6'h02;
        for (int i = 0; i < 5; i++) tick();
        check("mid.pre_reset_pos", int'(pos), 0);
        reset = 1'b1; tick();
        check_outs("mid.reset_edge", 6'h00, 3'd6, 1'b0, 1'b0);
        reset = 1'b0;
        run_until(6'h02, 10, e_n, s_n);
        check("mid.edge", e_n, 6);
        check("mid.strobes", s_n, 1);

        // Bounce on sensor 3: pattern 1,1,1,0 x5, then held high.
        reset = 1'b1; sensor_raw = 6'h00; tick();
        reset = 1'b0; tick();
        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                sensor_raw = ((i % 4) == 3) ? 6'h00 : 6'h08;
                tick();
                if (pos !== 6'h00 || change_strobe !== 1'b0) bad++;
            end
            check("bounce.disturbed_cycles", bad, 0);
        end
        sensor_raw = 6'h08;
        run_until(6'h08, 10, e_n, s_n);
        check("bounce.edge", e_n, 6);
        check("bounce.strobes", s_n, 1);
        check_outs("bounce.final", 6'h08, 3'd5, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
